// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package imem_fetch_pkg;

   localparam int DEF_PC_W    = 8;
   localparam int DEF_INSTR_W = 32;
   localparam int PC_STEP     = 4;
   localparam int FETCH_DEPTH = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [DEF_PC_W-1:0]    pc;
      logic [DEF_INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_buf.sv
// Two-entry in-order queue of fetched {pc, instr} words.
// The head always lives in slot 0, so the head outputs come straight from a flop.
module fetch_buf
   import imem_fetch_pkg::*;
#(
   parameter type entry_t = fetch_entry_t
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       push,
   input  entry_t     push_data,
   input  logic       pop,
   output logic [1:0] count,
   output logic       head_valid,
   output entry_t     head
);

   entry_t     slot_q [FETCH_DEPTH];
   entry_t     slot_d [FETCH_DEPTH];
   logic [1:0] count_q;
   logic [1:0] count_d;
   logic       pop_ok;
   logic       push_ok;
   logic [1:0] wr_idx;

   // Next-state of the queue: pop shifts slot 1 forward, push lands behind the survivors.
   always_comb begin
      slot_d  = slot_q;
      count_d = count_q;
      pop_ok  = pop & (count_q != 2'd0);
      wr_idx  = count_q - {1'b0, pop_ok};
      push_ok = push & (wr_idx < 2'(FETCH_DEPTH));
      if (flush) begin
         count_d = 2'd0;
      end else begin
         if (pop_ok) begin
            slot_d[0] = slot_q[1];
         end
         if (push_ok) begin
            slot_d[wr_idx[0]] = push_data;
         end
         count_d = count_q - {1'b0, pop_ok} + {1'b0, push_ok};
      end
   end

   // Queue storage and occupancy registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= 2'd0;
         for (int i = 0; i < FETCH_DEPTH; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         for (int i = 0; i < FETCH_DEPTH; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

   assign count      = count_q;
   assign head_valid = (count_q != 2'd0);
   assign head       = slot_q[0];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: drives the IMEM address, tracks the single
// outstanding read, and queues returned words for decode.
module imem_fetch_ctrl
   import imem_fetch_pkg::*;
#(
   parameter int               PC_W     = DEF_PC_W,
   parameter int               INSTR_W  = DEF_INSTR_W,
   parameter logic [PC_W-1:0]  RESET_PC = '0
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               FETCH_EN,
   input  logic               REDIRECT_VALID,
   input  logic [PC_W-1:0]    REDIRECT_PC,
   output logic [PC_W-1:0]    MEM_PC,
   input  logic [INSTR_W-1:0] IMEM_instruction,
   output logic               INSTR_VALID,
   output logic [PC_W-1:0]    INSTR_PC,
   output logic [INSTR_W-1:0] INSTR,
   input  logic               INSTR_READY
);

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] mem_pc_q, mem_pc_d;
   logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
   logic            inflight_q, inflight_d;
   logic            kill_q, kill_d;

   logic [1:0]      buf_count;
   logic            buf_valid;
   entry_t          buf_head;
   entry_t          push_entry;
   logic            deq;
   logic            issue;
   logic            push;
   logic [2:0]      credit_used;

   // Credit check, issue decision and next values for the address/in-flight/FSM flops.
   always_comb begin
      deq         = buf_valid & INSTR_READY;
      // Slots that will be taken once this cycle's return lands and the head leaves.
      credit_used = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, deq};
      issue       = (state_q == ST_RUN) & ~REDIRECT_VALID & (credit_used < 3'(FETCH_DEPTH));
      // A return coinciding with a redirect belongs to the abandoned path.
      push        = inflight_q & ~kill_q & ~REDIRECT_VALID;

      push_entry.pc    = inflight_pc_q;
      push_entry.instr = IMEM_instruction;

      state_d       = FETCH_EN ? ST_RUN : ST_IDLE;
      mem_pc_d      = mem_pc_q;
      inflight_pc_d = inflight_pc_q;
      inflight_d    = issue;
      // Marks the cycle after a redirect so nothing tagged before the flush can land.
      kill_d        = REDIRECT_VALID;

      if (REDIRECT_VALID) begin
         mem_pc_d = REDIRECT_PC & ~(PC_W'(3));
      end else if (issue) begin
         inflight_pc_d = mem_pc_q;
         mem_pc_d      = mem_pc_q + PC_W'(PC_STEP);
      end
   end

   // FSM state, fetch address and outstanding-read tracking.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q       <= ST_IDLE;
         mem_pc_q      <= RESET_PC;
         inflight_pc_q <= '0;
         inflight_q    <= 1'b0;
         kill_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         mem_pc_q      <= mem_pc_d;
         inflight_pc_q <= inflight_pc_d;
         inflight_q    <= inflight_d;
         kill_q        <= kill_d;
      end
   end

   fetch_buf #(
      .entry_t (entry_t)
   ) u_buf (
      .clk        (CLK),
      .rst_n      (RST_N),
      .flush      (REDIRECT_VALID),
      .push       (push),
      .push_data  (push_entry),
      .pop        (deq),
      .count      (buf_count),
      .head_valid (buf_valid),
      .head       (buf_head)
   );

   assign MEM_PC      = mem_pc_q;
   assign INSTR_VALID = buf_valid;
   assign INSTR_PC    = buf_head.pc;
   assign INSTR       = buf_head.instr;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_imem_fetch_ctrl;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        FETCH_EN = 1'b0;
   logic        REDIRECT_VALID = 1'b0;
   logic [7:0]  REDIRECT_PC = 8'h00;
   logic [7:0]  MEM_PC;
   logic [31:0] IMEM_instruction = 32'h0;
   logic        INSTR_VALID;
   logic [7:0]  INSTR_PC;
   logic [31:0] INSTR;
   logic        INSTR_READY = 1'b0;

   always #5 CLK = ~CLK;

   // IMEM: 64 words, one-cycle registered read.
   logic [31:0] mem [64];
   always @(posedge CLK) IMEM_instruction <= mem[MEM_PC[7:2]];

   imem_fetch_ctrl u_dut (
      .CLK              (CLK),
      .RST_N            (RST_N),
      .FETCH_EN         (FETCH_EN),
      .REDIRECT_VALID   (REDIRECT_VALID),
      .REDIRECT_PC      (REDIRECT_PC),
      .MEM_PC           (MEM_PC),
      .IMEM_instruction (IMEM_instruction),
      .INSTR_VALID      (INSTR_VALID),
      .INSTR_PC         (INSTR_PC),
      .INSTR            (INSTR),
      .INSTR_READY      (INSTR_READY)
   );

   typedef struct { logic [7:0] pc; logic [31:0] ins; } ent_t;
   typedef struct { int cyc; logic [7:0] pc; logic [31:0] ins; } beat_t;

   // Reference model: buffered words, pending read, fetch address, run flag.
   ent_t       m_fifo[$];
   bit         m_known = 0;
   bit         m_run = 0;
   bit         m_pend = 0;
   logic [7:0] m_pc = 8'h00;
   logic [7:0] m_pend_pc = 8'h00;

   beat_t      beats[$];
   int         cyc = 0;
   int         n_chk = 0;
   int         n_err = 0;
   int         rel;
   logic [31:0] plan [4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Advance the model by one clock edge using the rules of the fetch unit.
   task automatic model_update(input bit rn, input bit fe, input bit rv,
                               input logic [7:0] rp, input bit rdy);
      bit   deq;
      bit   issue;
      int   occ;
      ent_t e;
      if (!rn) begin
         m_fifo.delete();
         m_pend  = 0;
         m_pc    = 8'h00;
         m_run   = 0;
         m_known = 1;
         return;
      end
      deq   = (m_fifo.size() > 0) && rdy;
      occ   = m_fifo.size() + int'(m_pend) - int'(deq);
      issue = m_run && !rv && (occ < 2);
      if (deq) void'(m_fifo.pop_front());
      if (rv) begin
         m_fifo.delete();
         m_pc = rp & 8'hFC;
      end else begin
         if (m_pend) begin
            e.pc  = m_pend_pc;
            e.ins = mem[m_pend_pc[7:2]];
            m_fifo.push_back(e);
         end
         if (issue) begin
            m_pend_pc = m_pc;
            m_pc      = m_pc + 8'd4;
         end
      end
      m_pend = issue;
      m_run  = fe;
   endtask

   // One clock cycle: drive inputs, compare outputs with the model, log a beat, advance.
   task automatic step(input bit rn, input bit fe, input bit rv,
                       input logic [7:0] rp, input bit rdy);
      beat_t b;
      @(negedge CLK);
      RST_N          = rn;
      FETCH_EN       = fe;
      REDIRECT_VALID = rv;
      REDIRECT_PC    = rp;
      INSTR_READY    = rdy;
      if (m_known) begin
         check("mem_pc", {24'h0, MEM_PC}, {24'h0, m_pc});
         check("instr_valid", {31'h0, INSTR_VALID}, {31'h0, m_fifo.size() != 0});
         if (m_fifo.size() != 0) begin
            check("instr_pc", {24'h0, INSTR_PC}, {24'h0, m_fifo[0].pc});
            check("instr", INSTR, m_fifo[0].ins);
         end
      end
      if (rn && rdy && INSTR_VALID === 1'b1) begin
         b.cyc = cyc;
         b.pc  = INSTR_PC;
         b.ins = INSTR;
         beats.push_back(b);
         $display("beat cyc=%0d pc=%02h instr=%08h", cyc, INSTR_PC, INSTR);
      end
      model_update(rn, fe, rv, rp, rdy);
      @(posedge CLK);
      cyc++;
   endtask

   initial begin
      plan[0] = 32'h20090004;
      plan[1] = 32'h200B0005;
      plan[2] = 32'h012B5020;
      plan[3] = 32'h8D490004;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      for (int i = 0; i < 4; i++) mem[i] = plan[i];

      // Reset, then stream with decode always ready.
      step(0, 0, 0, 8'h00, 1);
      step(0, 0, 0, 8'h00, 1);
      #1;
      check("rst_valid", {31'h0, INSTR_VALID}, 32'h0);
      check("rst_instr_pc", {24'h0, INSTR_PC}, 32'h0);
      check("rst_instr", INSTR, 32'h0);
      check("rst_mem_pc", {24'h0, MEM_PC}, 32'h0);
      beats.delete();
      rel = cyc;
      repeat (10) step(1, 1, 0, 8'h00, 1);
      check("s1_nbeats", {31'h0, beats.size() >= 4}, 32'h1);
      if (beats.size() >= 4) begin
         check("s1_first_cyc", beats[0].cyc, rel + 3);
         for (int i = 0; i < 4; i++) begin
            check("s1_pc", {24'h0, beats[i].pc}, 4 * i);
            check("s1_instr", beats[i].ins, plan[i]);
            check("s1_cyc", beats[i].cyc, beats[0].cyc + i);
         end
      end

      // Decode stalls for the first cycles; head must hold, order must survive.
      step(0, 0, 0, 8'h00, 1);
      beats.delete();
      rel = cyc;
      repeat (8) step(1, 1, 0, 8'h00, 0);
      check("s2_stall_head_pc", {24'h0, INSTR_PC}, 32'h0);
      check("s2_stall_head", INSTR, plan[0]);
      repeat (10) step(1, 1, 0, 8'h00, 1);
      check("s2_nbeats", {31'h0, beats.size() >= 4}, 32'h1);
      if (beats.size() >= 4) begin
         check("s2_first_cyc", beats[0].cyc, rel + 8);
         for (int i = 0; i < 4; i++) begin
            check("s2_pc", {24'h0, beats[i].pc}, 4 * i);
            check("s2_instr", beats[i].ins, plan[i]);
         end
      end

      // Redirect to an unaligned target while the buffer is full.
      step(0, 1, 0, 8'h00, 0);
      repeat (6) step(1, 1, 0, 8'h00, 0);
      beats.delete();
      rel = cyc;
      step(1, 1, 1, 8'h0B, 0);
      repeat (8) step(1, 1, 0, 8'h00, 1);
      check("s3_nbeats", {31'h0, beats.size() >= 2}, 32'h1);
      if (beats.size() >= 2) begin
         check("s3_pc0", {24'h0, beats[0].pc}, 32'h08);
         check("s3_instr0", beats[0].ins, plan[2]);
         check("s3_cyc0", beats[0].cyc, rel + 3);
         check("s3_pc1", {24'h0, beats[1].pc}, 32'h0C);
      end

      // Redirect near the top of the address space: fetch wraps to 00.
      rel = cyc;
      step(1, 1, 1, 8'hF8, 1);
      beats.delete();
      repeat (8) step(1, 1, 0, 8'h00, 1);
      check("s4_nbeats", {31'h0, beats.size() >= 4}, 32'h1);
      if (beats.size() >= 4) begin
         check("s4_cyc0", beats[0].cyc, rel + 3);
         check("s4_pc0", {24'h0, beats[0].pc}, 32'hF8);
         check("s4_pc1", {24'h0, beats[1].pc}, 32'hFC);
         check("s4_pc2", {24'h0, beats[2].pc}, 32'h00);
         check("s4_pc3", {24'h0, beats[3].pc}, 32'h04);
         check("s4_instr2", beats[2].ins, plan[0]);
      end

      // Fetch enable drops: drain, go quiet, then resume at the next PC.
      repeat (7) step(1, 0, 0, 8'h00, 1);
      #1;
      check("s5_quiet_valid", {31'h0, INSTR_VALID}, 32'h0);
      repeat (8) step(1, 1, 0, 8'h00, 1);
      check("s5_nbeats", {31'h0, beats.size() >= 10}, 32'h1);
      for (int i = 1; i < beats.size(); i++) begin
         check("s5_seq_pc", {24'h0, beats[i].pc}, {24'h0, beats[i-1].pc + 8'd4});
         check("s5_seq_instr", beats[i].ins, mem[beats[i].pc[7:2]]);
      end

      // One-cycle reset in the middle of a stream.
      step(0, 1, 0, 8'h00, 1);
      #1;
      check("s6_valid", {31'h0, INSTR_VALID}, 32'h0);
      check("s6_mem_pc", {24'h0, MEM_PC}, 32'h0);
      beats.delete();
      rel = cyc;
      repeat (8) step(1, 1, 0, 8'h00, 1);
      check("s6_nbeats", {31'h0, beats.size() >= 1}, 32'h1);
      if (beats.size() >= 1) begin
         check("s6_pc0", {24'h0, beats[0].pc}, 32'h0);
         check("s6_cyc0", beats[0].cyc, rel + 3);
      end

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         step($urandom_range(0, 99) >= 2,
              $urandom_range(0, 99) < 85,
              $urandom_range(0, 99) < 5,
              8'($urandom),
              $urandom_range(0, 99) < 70);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
